mem_stage_ls: RTL and testbench
===============================

MEM_STAGE_LS -- requirements
Module: mem_stage_ls

Interface
- REQ-001: Parameter REG_ADDR_WIDTH, default 5, is the width of the destination register address.
- REQ-002: Parameter MEM_ADDR_WIDTH, default 32, is the width of the data-memory byte address.
- REQ-003: Parameter ACK_TIMEOUT, default 15, is the maximum cycles spent waiting for dmem_ack; legal range 1..255.
- REQ-004: clk  in  1  rising-edge clock.
- REQ-005: rst_n  in  1  reset, synchronous, active-low.
- REQ-006: in_valid / in_ready  in / out  1 / 1  EX-side handshake; a transfer occurs when both are 1 on a rising edge.
- REQ-007: w_reg_addr_in, w_reg_data_in, w_reg_en_in  in  REG_ADDR_WIDTH / 32 / 1  writeback fields from EX.
- REQ-008: mem_op  in  4  0=NONE, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW; codes 9..15 decode as NONE.
- REQ-009: mem_addr, mem_wdata  in  MEM_ADDR_WIDTH / 32  byte address and store data.
- REQ-010: out_valid / out_ready  out / in  1 / 1  WB-side handshake.
- REQ-011: w_reg_addr_out, w_reg_data_out, w_reg_en_out  out  REG_ADDR_WIDTH / 32 / 1  registered writeback fields.
- REQ-012: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata  out  1 / 1 / 4 / MEM_ADDR_WIDTH / 32  memory request; dmem_addr is word-aligned (low two bits 0).
- REQ-013: dmem_ack, dmem_rdata  in  1 / 32  memory completion; dmem_rdata is valid when dmem_ack is 1.
- REQ-014: bus_err  out  1  one-cycle pulse when a request times out.

Function
- REQ-015: The FSM SHALL have states IDLE, REQ and HOLD; in_ready SHALL be 1 only in IDLE.
- REQ-016: IDLE, accepting a NONE op: register the fields unchanged, out_valid=1, go to HOLD; latency 1 cycle.
- REQ-017: IDLE, accepting a load/store: latch all fields, go to REQ; dmem_req=1 in every REQ cycle with stable addr/be/wdata/we.
- REQ-018: Byte enables: byte -> 1 lane selected by addr[1:0]; half -> lanes {1,0} or {3,2} by addr[1]; word -> 4'b1111.
- REQ-019: Stores SHALL replicate the byte or half across lanes in dmem_wdata and force w_reg_en_out=0.
- REQ-020: Loads SHALL extract the addressed lane, sign-extend (LB, LH) or zero-extend (LBU, LHU) to 32 bits, and drive it on w_reg_data_out.
- REQ-021: REQ with dmem_ack=1: capture the result, out_valid=1, go to HOLD; memory latency = 1 + ack wait cycles.
- REQ-022: A wait counter SHALL count REQ cycles without ack; at ACK_TIMEOUT it SHALL pulse bus_err, drop dmem_req, present the op with w_reg_en_out=0 and go to HOLD.
- REQ-023: HOLD: outputs SHALL remain stable until out_valid and out_ready are both 1, then go to IDLE with out_valid=0.
- REQ-024: dmem_ack outside REQ SHALL be ignored.
- REQ-025: No new op is accepted in the same cycle as the HOLD handoff, so the stage throughput is at most one op per two cycles.

Reset
- REQ-026: While rst_n=0 on a clock edge: state=IDLE, the counter clears, and all outputs are 0 except in_ready=1.
- REQ-027: Reset asserted in REQ or HOLD SHALL abandon the op; dmem_req SHALL be 0 in the cycle after the reset edge.

Configuration
- REQ-028: With MEM_MISALIGN_TRAP_EN defined, a half op with addr[0]=1 or a word op with addr[1:0]!=0 SHALL issue no request. It SHALL go directly to HOLD with w_reg_en_out=0 and a 1-cycle pulse on the extra output misalign_exc.
- REQ-029: Without MEM_MISALIGN_TRAP_EN, port misalign_exc SHALL not exist and misaligned low address bits are ignored: a half uses addr[1], and a word is treated as aligned.

Verification
- REQ-030: NONE op with data 0xDEADBEEF, reg 3, en 1, out_ready=1 -> out_valid the next cycle with identical fields; no dmem_req.
- REQ-031: LB at addr 0x1003, rdata 0x80FF_0000, ack after 2 cycles -> be=4'b1000, w_reg_data_out=0xFFFFFF80; LBU on the same access -> 0x00000080.
- REQ-032: SH at addr 0x2002, wdata 0x1234ABCD -> be=4'b1100, dmem_wdata=0xABCDABCD, we=1, w_reg_en_out=0.
- REQ-033: LW with dmem_ack never asserted, ACK_TIMEOUT=15 -> exactly 15 req cycles, then a single bus_err pulse and out_valid with w_reg_en_out=0.
- REQ-034: out_ready held at 0 for 5 cycles after a LHU result 0x0000BEEF -> outputs stable and in_ready=0 throughout; rst_n=0 during REQ -> dmem_req=0 the next cycle.
- REQ-035: With MEM_MISALIGN_TRAP_EN defined, LW at 0x0002 -> no dmem_req, misalign_exc pulses once.

Source files
------------

// File: rtl/mem_stage_ls.sv
// mem_stage_ls: MEM pipeline stage issuing loads/stores to a word-wide data memory, with ack timeout.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word ops trap on misalign_exc instead of issuing.
module mem_stage_ls #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int ACK_TIMEOUT    = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
    input  logic [31:0]               w_reg_data_in,
    input  logic                      w_reg_en_in,
    input  logic [3:0]                mem_op,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]               mem_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_ADDR_WIDTH-1:0] w_reg_addr_out,
    output logic [31:0]               w_reg_data_out,
    output logic                      w_reg_en_out,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [3:0]                dmem_be,
    output logic [MEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]               dmem_wdata,
    input  logic                      dmem_ack,
    input  logic [31:0]               dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                      misalign_exc,
`endif
    output logic                      bus_err
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Last wait-counter value before the request is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD} state_t;

    state_t                    r_state;
    logic [7:0]                r_wait_cnt;
    logic [3:0]                r_op;
    logic [1:0]                r_off;
    logic                      r_is_ld;
    logic                      r_en_in;
    logic                      r_out_valid;
    logic [REG_ADDR_WIDTH-1:0] r_reg_addr;
    logic [31:0]               r_reg_data;
    logic                      r_reg_en;
    logic                      r_req;
    logic                      r_we;
    logic [3:0]                r_be;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [31:0]               r_wdata;
    logic                      r_bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                      r_mis;
    logic                      w_misalign;
`endif

    logic [3:0]  w_op;
    logic        w_is_ld;
    logic        w_is_st;
    logic [1:0]  w_size;
    logic [3:0]  w_be;
    logic [31:0] w_st_data;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    // Request-side decode of the incoming op; reserved codes fold to NONE.
    always_comb begin
        w_op    = (mem_op > OP_SW) ? OP_NONE : mem_op;
        w_is_ld = (w_op >= OP_LB) && (w_op <= OP_LW);
        w_is_st = (w_op >= OP_SB);
        case (w_op)
            OP_LB, OP_LBU, OP_SB: w_size = SZ_B;
            OP_LH, OP_LHU, OP_SH: w_size = SZ_H;
            default:              w_size = SZ_W;
        endcase
        case (w_size)
            SZ_B:    w_be = 4'b0001 << mem_addr[1:0];
            SZ_H:    w_be = mem_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
        case (w_op)
            OP_SB:   w_st_data = {4{mem_wdata[7:0]}};
            OP_SH:   w_st_data = {2{mem_wdata[15:0]}};
            OP_SW:   w_st_data = mem_wdata;
            default: w_st_data = 32'h0;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == SZ_H) && mem_addr[0]) ||
                        ((w_size == SZ_W) && (mem_addr[1:0] != 2'b00));
`endif

    // Response-side lane extraction, using the byte offset latched at accept.
    always_comb begin
        w_ld_byte = 8'(dmem_rdata >> {r_off, 3'b000});
        w_ld_half = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_op)
            OP_LB:   w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            OP_LBU:  w_ld_data = {24'h0, w_ld_byte};
            OP_LH:   w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            OP_LHU:  w_ld_data = {16'h0, w_ld_half};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_op        <= OP_NONE;
            r_off       <= '0;
            r_is_ld     <= 1'b0;
            r_en_in     <= 1'b0;
            r_out_valid <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_data  <= '0;
            r_reg_en    <= 1'b0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_bus_err   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_mis       <= 1'b0;
`endif
        end else begin
            r_bus_err <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_mis     <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_reg_addr <= w_reg_addr_in;
                        r_reg_data <= w_reg_data_in;
                        r_en_in    <= w_reg_en_in;
                        r_op       <= w_op;
                        r_off      <= mem_addr[1:0];
                        r_is_ld    <= w_is_ld;
                        r_wait_cnt <= '0;
                        if (w_op == OP_NONE) begin
                            r_reg_en    <= w_reg_en_in;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_HOLD;
                        end
`ifdef MEM_MISALIGN_TRAP_EN
                        else if (w_misalign) begin
                            r_reg_en    <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_mis       <= 1'b1;
                            r_state     <= ST_HOLD;
                        end
`endif
                        else begin
                            // Writeback stays disabled until a load completes.
                            r_reg_en <= 1'b0;
                            r_req    <= 1'b1;
                            r_we     <= w_is_st;
                            r_be     <= w_be;
                            r_addr   <= {mem_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
                            r_wdata  <= w_st_data;
                            r_state  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_ack) begin
                        r_req       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                        if (r_is_ld) begin
                            r_reg_data <= w_ld_data;
                            r_reg_en   <= r_en_in;
                        end
                    end else if (r_wait_cnt == TMO_LAST) begin
                        r_req       <= 1'b0;
                        r_bus_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready       = (r_state == ST_IDLE);
    assign out_valid      = r_out_valid;
    assign w_reg_addr_out = r_reg_addr;
    assign w_reg_data_out = r_reg_data;
    assign w_reg_en_out   = r_reg_en;
    assign dmem_req       = r_req;
    assign dmem_we        = r_we;
    assign dmem_be        = r_be;
    assign dmem_addr      = r_addr;
    assign dmem_wdata     = r_wdata;
    assign bus_err        = r_bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_exc   = r_mis;
`endif

endmodule

// File: tb/tb_mem_stage_ls.sv
// tb_mem_stage_ls: random load/store traffic against a transaction-level model, plus directed spec cases.
// Honours MEM_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_stage_ls;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, w_reg_en_in, out_valid, out_ready, w_reg_en_out;
  logic [4:0]  w_reg_addr_in, w_reg_addr_out;
  logic [31:0] w_reg_data_in, w_reg_data_out, mem_addr, mem_wdata;
  logic [3:0]  mem_op, dmem_be;
  logic        dmem_req, dmem_we, dmem_ack, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  mem_stage_ls #(.REG_ADDR_WIDTH(5), .MEM_ADDR_WIDTH(32), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .w_reg_addr_in(w_reg_addr_in), .w_reg_data_in(w_reg_data_in), .w_reg_en_in(w_reg_en_in),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .w_reg_addr_out(w_reg_addr_out), .w_reg_data_out(w_reg_data_out), .w_reg_en_out(w_reg_en_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_exc(misalign_exc),
`endif
    .bus_err(bus_err)
  );

  typedef struct {
    int          op;
    logic [31:0] addr, wdata, rdata, data;
    logic [4:0]  rd;
    logic        en;
    int          ack_wait;  // REQ cycles without ack before the ack cycle
  } txn_t;

  typedef struct {
    bit          req, we, tmo, mis;
    logic [3:0]  be;
    logic [31:0] daddr, dwdata, data;
    logic [4:0]  rd;
    logic        en;
    int          reqc;
  } exp_t;

  int   checks = 0, errors = 0;
  txn_t cur;
  exp_t E;
  bit   chk_en = 0, outstanding = 0;
  int   cyc, start;
  int   obs_req, obs_berr, obs_mis, obs_outcyc;
  logic [3:0]  obs_be;
  logic        obs_we, obs_en;
  logic [31:0] obs_wdata, obs_data;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // What a transaction must produce, from the op semantics alone.
  function automatic exp_t model(txn_t t);
    exp_t e;
    int op, lane, sz;
    logic [31:0] v;
    e = '{default: '0};
    op = (t.op > 8) ? 0 : t.op;
    lane = int'(t.addr % 4);
    e.rd = t.rd; e.data = t.data; e.en = t.en;
    if (op == 0) return e;
    sz = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
    e.en = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (lane % sz != 0) begin e.mis = 1; return e; end
`endif
    e.req = 1; e.we = (op >= 6); e.daddr = t.addr - 32'(lane);
    e.be = (sz == 1) ? 4'(1 << lane) : (sz == 2) ? ((lane >= 2) ? 4'hC : 4'h3) : 4'hF;
    if (op == 6) e.dwdata = (t.wdata & 32'hFF) * 32'h0101_0101;
    else if (op == 7) e.dwdata = (t.wdata & 32'hFFFF) * 32'h0001_0001;
    else e.dwdata = t.wdata;
    e.tmo = (t.ack_wait >= TMO);
    e.reqc = e.tmo ? TMO : t.ack_wait + 1;
    if (!e.we && !e.tmo) begin
      if (sz == 1) begin
        v = (t.rdata >> (8 * lane)) & 32'hFF;
        if (op == 1 && v >= 128) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
        v = (t.rdata >> ((lane >= 2) ? 16 : 0)) & 32'hFFFF;
        if (op == 3 && v >= 32768) v = v | 32'hFFFF_0000;
      end else v = t.rdata;
      e.data = v; e.en = t.en;
    end
    return e;
  endfunction

  // Memory responder: acks after the programmed wait; random ack noise while no request is up.
  initial begin
    int rc;
    rc = 0; dmem_ack = 0; dmem_rdata = 0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        rc++;
        dmem_ack = (rc == cur.ack_wait + 1);
        dmem_rdata = dmem_ack ? cur.rdata : $urandom;
      end else begin
        rc = 0;
        dmem_ack = 1'($urandom % 2);
        dmem_rdata = $urandom;
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the model's expectation for the op in flight.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (!outstanding) begin
        chk("idle_ctrl", {in_ready, out_valid, dmem_req, bus_err}, 4'b1000);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("idle_mis", misalign_exc, 0);
`endif
      end else begin
        cyc++;
        start = E.req ? E.reqc + 1 : 1;
        chk("busy_in_ready", in_ready, 0);
        if (E.req && cyc <= E.reqc) begin
          chk("req", dmem_req, 1);
          chk("req_fields", {dmem_we, dmem_be, dmem_addr}, {E.we, E.be, E.daddr});
          if (E.we) chk("req_wdata", dmem_wdata, E.dwdata);
          obs_req++; obs_be = dmem_be; obs_we = dmem_we; obs_wdata = dmem_wdata;
        end else chk("no_req", dmem_req, 0);
        if (cyc >= start) begin
          chk("out_valid", out_valid, 1);
          chk("out_fields", {w_reg_addr_out, w_reg_en_out, w_reg_data_out}, {E.rd, E.en, E.data});
          chk("bus_err", bus_err, E.tmo && cyc == start);
          if (obs_outcyc == 0) obs_outcyc = cyc;
          obs_data = w_reg_data_out; obs_en = w_reg_en_out;
        end else begin
          chk("out_valid_early", out_valid, 0);
          chk("bus_err_early", bus_err, 0);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        chk("misalign_exc", misalign_exc, E.mis && cyc == start);
        obs_mis += int'(misalign_exc);
`endif
        obs_berr += int'(bus_err);
      end
    end
  end

  task automatic scramble();
    in_valid = 0; mem_op = 4'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
    w_reg_addr_in = 5'($urandom); w_reg_data_in = $urandom; w_reg_en_in = 1'($urandom);
  endtask

  task automatic issue(txn_t t);
    cur = t; E = model(t);
    @(negedge clk);
    in_valid = 1; mem_op = 4'(t.op); mem_addr = t.addr; mem_wdata = t.wdata;
    w_reg_addr_in = t.rd; w_reg_data_in = t.data; w_reg_en_in = t.en;
    @(posedge clk);
    #1 scramble();
  endtask

  task automatic run(txn_t t, int rdy_dly);
    int n;
    issue(t);
    outstanding = 1; cyc = 0; obs_req = 0; obs_berr = 0; obs_mis = 0; obs_outcyc = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 40);
    chk("wait_out_valid", out_valid, 1);
    repeat (rdy_dly) @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    outstanding = 0;
    #1 out_ready = 0;
  endtask

  function automatic txn_t mk(int op, logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              logic [31:0] data, logic [4:0] rd, logic en, int aw);
    txn_t t;
    t.op = op; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    t.data = data; t.rd = rd; t.en = en; t.ack_wait = aw;
    return t;
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    scramble(); out_ready = 0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {in_ready, out_valid, dmem_req, bus_err, w_reg_en_out, dmem_we}, 6'b100000);
    chk("rst_data", {w_reg_data_out, dmem_addr}, 64'h0);
    chk("rst_fields", {w_reg_addr_out, dmem_be, dmem_wdata}, 41'h0);
    rst_n = 1; chk_en = 1;

    run(mk(0, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd3, 1'b1, 0), 0);
    chk("none_latency", obs_outcyc, 1);
    chk("none_noreq", obs_req, 0);
    chk("none_data", {obs_en, obs_data}, {1'b1, 32'hDEAD_BEEF});

    run(mk(1, 32'h1003, 32'h0, 32'h80FF_0000, 32'h0, 5'd7, 1'b1, 2), 1);
    chk("lb_be", obs_be, 4'b1000);
    chk("lb_reqc", obs_req, 3);
    chk("lb_data", obs_data, 32'hFFFF_FF80);
    run(mk(2, 32'h1003, 32'h0, 32'h80FF_0000, 32'h0, 5'd7, 1'b1, 2), 0);
    chk("lbu_data", obs_data, 32'h0000_0080);

    run(mk(7, 32'h2002, 32'h1234_ABCD, 32'h0, 32'h5, 5'd9, 1'b1, 0), 0);
    chk("sh_be", obs_be, 4'b1100);
    chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    chk("sh_we_en", {obs_we, obs_en}, 2'b10);

    run(mk(5, 32'h100, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 1000), 2);
    chk("tmo_reqc", obs_req, 15);
    chk("tmo_berr", obs_berr, 1);
    chk("tmo_en", obs_en, 0);

    run(mk(4, 32'h2, 32'h0, 32'hBEEF_0000, 32'h0, 5'd1, 1'b1, 1), 5);
    chk("lhu_data", obs_data, 32'h0000_BEEF);

`ifdef MEM_MISALIGN_TRAP_EN
    run(mk(5, 32'h2, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 0), 0);
    chk("mis_noreq", obs_req, 0);
    chk("mis_pulse", obs_mis, 1);
`endif

    // Reset while a request is outstanding abandons it.
    chk_en = 0;
    issue(mk(5, 32'h40, 32'h0, 32'h0, 32'h0, 5'd1, 1'b1, 1000));
    repeat (3) @(negedge clk);
    chk("pre_rst_req", dmem_req, 1);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("rst_req_drop", {dmem_req, out_valid, in_ready}, 3'b001);
    @(negedge clk);
    rst_n = 1; chk_en = 1;

    for (int i = 0; i < 200; i++) begin
      t.op = ($urandom % 8 == 0) ? 9 + int'($urandom % 7) : int'($urandom % 9);
      t.addr = $urandom; t.wdata = $urandom; t.rdata = $urandom; t.data = $urandom;
      t.rd = 5'($urandom); t.en = 1'($urandom);
      case ($urandom % 10)
        0: t.ack_wait = 14;
        1: t.ack_wait = 15 + int'($urandom % 3);
        default: t.ack_wait = int'($urandom % 4);
      endcase
      run(t, int'($urandom % 4));
      repeat ($urandom % 3) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
